des_decrypt_iter: RTL
=====================

Name: des_decrypt_iter

Overview:
Iterative DES decryption core, the inverse-direction counterpart of des_top.
- Accepts a 64-bit cipher text and a 64-bit key on a start pulse and runs 16 Feistel rounds, one per clock, with subkeys applied in reverse order (K16 to K1).
- Returns the 64-bit plain text with a one-cycle done pulse.
- Sits beside des_top so the bench and the system can round-trip encrypt and decrypt.

Parameters:
- NUM_ROUNDS, 16, number of Feistel rounds; fixed at 16 for standard DES and kept only for the bench's counter checks.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request decryption; sampled only when not busy.
- cipher_key  input  64  DES key, bit 63 = DES bit 1; parity bits (DES bits 8,16,...,64) ignored.
- cipher_text  input  64  block to decrypt, bit 63 = DES bit 1.
- plain_text  output  64  decrypted block, registered, held until the next completion.
- busy  output  1  high while rounds are in progress.
- done  output  1  one-cycle pulse when plain_text is updated.

Behaviour:
- Reset: rst sampled high at a clk edge forces the following, regardless of state:
  - state = IDLE
  - plain_text = 64'h0, busy = 0, done = 0
  - round counter = 0, L/R/C/D registers = 0
- Reset mid-operation aborts the operation. No done pulse is produced and plain_text is not updated.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - start = 1 at an edge captures the inputs:
    - L/R = IP(cipher_text) halves
    - C/D = PC1(cipher_key) halves
    - counter = 0
  - Transition to ROUND, busy = 1.
  - start = 0 stays in IDLE.
- ROUND, one round per edge:
  - R' = L xor f(R, PC2(C,D)), L' = R.
  - Round 1 uses C/D unrotated, which equals K16.
  - After each of rounds 1..15, C and D are each rotated right by the next amount in the sequence 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. This is the encryption left-shift schedule reversed, rounds 16..2.
  - Counter increments each round.
- On the edge executing round 16 (counter = 15):
  - plain_text <= FP(R16 || L16), i.e. swapped halves.
  - State goes to DONE, done = 1, busy = 0.
- Latency: start sampled at edge E0 gives done = 1 and valid plain_text in the cycle after edge E16. That is 16 clock cycles, with no dead cycles.
- DONE:
  - Lasts exactly one cycle, with done = 1.
  - start = 1 in DONE is accepted exactly as in IDLE (back-to-back operation, 17-cycle throughput per block); otherwise return to IDLE.
- start while in ROUND is ignored, with no queuing.
- cipher_text and cipher_key changes after capture have no effect on the operation in flight.
- plain_text changes only on the round-16 edge or on reset.
- busy and done are never high simultaneously.
- busy = 1 for exactly 16 cycles per operation.
- All datapath widths are fixed: 28-bit C/D, 48-bit subkey and expansion, 32-bit halves. There is no arithmetic beyond XOR and rotation; rotation wraps within 28 bits.

Decomposition:
- Shared package des_pkg, also to be used by des_top, holds:
  - IP, FP, E, P, PC1 and PC2 permutation tables as localparam arrays
  - the eight S-box tables
  - the 16-entry encryption shift schedule
  - helper functions for permutation application
- Decryption derives its right-rotate amounts from the shared schedule by indexing 16-counter.
- One sub-module: des_round_f, a combinational f-function (E expansion, subkey XOR, S-boxes, P) with inputs R[31:0] and K[47:0] and output [31:0]. It is shareable with the encryption core.

Test Plan:
- Reset: assert rst 2 cycles mid-run (at round 7) -> busy = 0 and done = 0 next cycle, plain_text = 0, and no done pulse follows.
- Known vector: key 133457799BBCDFF1, cipher_text 85E813540F0AB405, start 1 cycle -> done after exactly 16 cycles, plain_text = 0123456789ABCDEF.
- Second vector: key 0E329232EA6D0D73, cipher_text 0000000000000000 -> plain_text = 8787878787878787. Repeat with key parity bits flipped (0F339333EB6C0C72) -> same result.
- Back-to-back: assert start in the DONE cycle with a new vector -> second done exactly 17 cycles after the first. The first result stays held until the second done.
- Ignored start and input stability: pulse start and change cipher_text/cipher_key during ROUND -> exactly one done, result matches the originally captured inputs, busy high for exactly 16 cycles.
- Round-trip: for 50 random key/plain pairs, des_top output fed into des_decrypt_iter -> plain_text equals the original plain input.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, key schedule and permutation helpers.
// Bit 63 of every vector is DES bit 1; table entries are 1-based DES bit numbers.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Encryption left-shift schedule, rounds 1..16
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // S-boxes, each flattened row-major: index = {row[1:0], col[3:0]}
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[5'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[6'(i)])];
        return y;
    endfunction

    // Schedule amounts are only ever 1 or 2
    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_round_f.sv
// DES f-function: E expansion, subkey XOR, S-box substitution, P permutation.
module des_round_f
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f_c
);

    logic [47:0] x;
    logic [31:0] s;

    assign x = perm_e(r) ^ k;

    // Row comes from the outer bits of each 6-bit group, column from the inner four
    for (genvar j = 0; j < 8; j++) begin : g_sbox
        logic [5:0] b;
        assign b = x[47 - 6*j -: 6];
        assign s[31 - 4*j -: 4] = 4'(SBOX[3'(j)][{b[5], b[0], b[4:1]}]);
    end

    assign f_c = perm_p(s);

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: one Feistel round per clock, subkeys generated K16 down to K1
// by right-rotating C/D with the encryption schedule read backwards.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] cipher_key,
    input  logic [63:0] cipher_text,
    output logic [63:0] plain_text,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = 4;

    state_t           state, state_d;
    logic             busy_d, done_d;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      l_q, r_q, f_out, r_new;
    logic [27:0]      c_q, d_q;
    logic [47:0]      subkey;
    logic [55:0]      cd_init;
    logic [63:0]      ip_ct;
    logic [1:0]       rot_amt;
    logic             last_round, accept;

    assign last_round = (cnt == CNT_W'(NUM_ROUNDS - 1));
    assign accept     = start && (state != ROUND);
    assign cd_init    = perm_pc1(cipher_key);
    assign ip_ct      = perm_ip(cipher_text);
    assign subkey     = perm_pc2({c_q, d_q});
    assign r_new      = l_q ^ f_out;
    assign rot_amt    = 2'(SHIFTS[CNT_W'(15) - cnt]);

    des_round_f u_round_f (
        .r   (r_q),
        .k   (subkey),
        .f_c (f_out)
    );

    // State register plus registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = ROUND;
            ROUND:   if (last_round) state_d = DONE;
            DONE:    state_d = start ? ROUND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == ROUND);
        done_d = (state_d == DONE);
    end

    // Round datapath; the final rotation after round 16 is harmless since C/D reload on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            l_q <= '0;
            r_q <= '0;
            c_q <= '0;
            d_q <= '0;
            cnt <= '0;
        end else if (accept) begin
            l_q <= ip_ct[63:32];
            r_q <= ip_ct[31:0];
            c_q <= cd_init[55:28];
            d_q <= cd_init[27:0];
            cnt <= '0;
        end else if (state == ROUND) begin
            l_q <= r_q;
            r_q <= r_new;
            c_q <= rotr28(c_q, rot_amt);
            d_q <= rotr28(d_q, rot_amt);
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Result takes the swapped halves R16 || L16
    always_ff @(posedge clk) begin
        if (rst) begin
            plain_text <= '0;
        end else if (state == ROUND && last_round) begin
            plain_text <= perm_fp({r_new, r_q});
        end
    end

endmodule
